// File: rtl/mux_arbiter4_if.sv
// Requester/resource handshake bundle for the 4-way round-robin mux arbiter.
// The master side is the requester/resource environment; the slave side is the arbiter.
interface mux_arbiter4_if;
    logic [3:0] req;
    logic       ack;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       valid;
    logic [3:0] done;
    logic       err;
    logic       busy;

    modport master (
        output req, ack,
        input  gnt, sel, valid, done, err, busy
    );

    modport slave (
        input  req, ack,
        output gnt, sel, valid, done, err, busy
    );
endinterface

// File: rtl/mux_arbiter4.sv
// Round-robin arbiter driving a mux4 select: grants one requester per transaction,
// holds until ACK, drop-out or timeout, then rotates priority past the winner.
module mux_arbiter4 #(
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              reset,
    mux_arbiter4_if.slave     bus
);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t          state_r, state_s;
    logic [1:0]      ptr_r, ptr_s;
    logic [CW-1:0]   cnt_r, cnt_s;
    logic [3:0]      gnt_r, gnt_s;
    logic [1:0]      sel_r, sel_s;
    logic            valid_r, valid_s;
    logic [3:0]      done_r, done_s;
    logic            err_r, err_s;
    logic            busy_r, busy_s;
    logic [1:0]      win_s;

    // First requester found scanning ptr, ptr+1, ... modulo 4.
    function automatic logic [1:0] rr_pick(input logic [3:0] req, input logic [1:0] ptr);
        logic [1:0] idx;
        logic       found;
        rr_pick = ptr;
        found   = 1'b0;
        for (int i = 0; i < 4; i++) begin
            idx = ptr + 2'(i);
            if (!found && req[idx]) begin
                rr_pick = idx;
                found   = 1'b1;
            end
        end
    endfunction

    function automatic logic [3:0] onehot4(input logic [1:0] idx);
        onehot4 = 4'b0001 << idx;
    endfunction

    // Next-state and next-output decode; sel_r doubles as the current winner in GRANT.
    always_comb begin
        state_s = state_r;
        ptr_s   = ptr_r;
        cnt_s   = cnt_r;
        gnt_s   = gnt_r;
        sel_s   = sel_r;
        done_s  = 4'b0000;
        err_s   = 1'b0;
        win_s   = rr_pick(bus.req, ptr_r);
        case (state_r)
            IDLE: begin
                if (|bus.req) begin
                    gnt_s   = onehot4(win_s);
                    sel_s   = win_s;
                    cnt_s   = '0;
                    state_s = GRANT;
                end else begin
                    gnt_s   = 4'b0000;
                end
            end
            GRANT: begin
                if (bus.ack) begin
                    done_s  = onehot4(sel_r);
                    gnt_s   = 4'b0000;
                    ptr_s   = sel_r + 2'd1;
                    state_s = IDLE;
                end else if (!bus.req[sel_r]) begin
                    gnt_s   = 4'b0000;
                    ptr_s   = sel_r + 2'd1;
                    state_s = IDLE;
                end else if (cnt_r == CW'(TIMEOUT - 1)) begin
                    err_s   = 1'b1;
                    gnt_s   = 4'b0000;
                    ptr_s   = sel_r + 2'd1;
                    state_s = IDLE;
                end else begin
                    cnt_s   = cnt_r + CW'(1);
                end
            end
            default: begin
                gnt_s   = 4'b0000;
                state_s = IDLE;
            end
        endcase
        valid_s = |gnt_s;
        busy_s  = (state_s == GRANT);
    end

    // State and registered outputs; reset drops any in-flight transaction silently.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
            ptr_r   <= 2'd0;
            cnt_r   <= '0;
            gnt_r   <= 4'b0000;
            sel_r   <= 2'b00;
            valid_r <= 1'b0;
            done_r  <= 4'b0000;
            err_r   <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            ptr_r   <= ptr_s;
            cnt_r   <= cnt_s;
            gnt_r   <= gnt_s;
            sel_r   <= sel_s;
            valid_r <= valid_s;
            done_r  <= done_s;
            err_r   <= err_s;
            busy_r  <= busy_s;
        end
    end

    assign bus.gnt   = gnt_r;
    assign bus.sel   = sel_r;
    assign bus.valid = valid_r;
    assign bus.done  = done_r;
    assign bus.err   = err_r;
    assign bus.busy  = busy_r;
endmodule
